inst_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Accepts one PC per handshake and reads four bytes from the byte-wide memory port.
- Assembles them little-endian into a 32-bit instruction.
- Holds the instruction and its PC for the decode stage until decode accepts it.
- Supports a synchronous flush from branch resolution and a global pause (rdy_in).

---
 rtl/inst_fetch.sv | 114 +++++++++++
 tb/tb_inst_fetch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: takes one PC, reads four bytes, and assembles them little-endian into a 32-bit word.
// The word is valid 5 cycles after PC accept when grants are continuous. The word is held until decode takes it. rdy_in pauses the stage and flush_in discards the fetch.
module inst_fetch #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pc_valid_in,
  output logic                  pc_ready_out,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_grant_in,
  input  logic [7:0]            mem_din_in,
  input  logic                  flush_in,
  output logic [31:0]           inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc_out,
  output logic                  inst_valid_out,
  input  logic                  id_ready_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            req_idx;
  logic [2:0]            rcv_idx;
  logic                  pend;

  logic                  accept;
  logic                  grant_take;
  logic                  last_done;
  logic                  complete;
  logic                  retire;

  assign pc_ready_out  = (state == IDLE) & ~flush_in & rdy_in;
  assign mem_rd_en_out = (state == FETCH) & (req_idx < 3'd4) & rdy_in;
  assign mem_addr_out  = base + ADDR_WIDTH'(req_idx);

  assign accept     = pc_valid_in & pc_ready_out;
  assign grant_take = mem_rd_en_out & mem_grant_in;
  // Lane 3 may land while paused; rcv_idx==4 remembers that so completion happens once rdy_in returns.
  assign last_done  = (pend & (rcv_idx == 3'd3)) | (rcv_idx == 3'd4);
  assign complete   = (state == FETCH) & rdy_in & last_done;
  assign retire     = (state == HOLD) & rdy_in & id_ready_in;

  always_comb begin
    state_nxt = state;
    if (flush_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)   state_nxt = FETCH;
        FETCH:   if (complete) state_nxt = HOLD;
        HOLD:    if (retire)   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      base           <= '0;
      req_idx        <= '0;
      rcv_idx        <= '0;
      pend           <= 1'b0;
      inst_out       <= '0;
      inst_pc_out    <= '0;
      inst_valid_out <= 1'b0;
    end else if (flush_in) begin
      req_idx        <= '0;
      rcv_idx        <= '0;
      pend           <= 1'b0;
      inst_valid_out <= 1'b0;
    end else begin
      pend <= grant_take;
      if (grant_take) begin
        req_idx <= req_idx + 3'd1;
      end
      // Memory returns a granted byte regardless of rdy_in, so capture is not gated by it.
      if (pend) begin
        inst_out[{rcv_idx[1:0], 3'b000} +: 8] <= mem_din_in;
        rcv_idx <= rcv_idx + 3'd1;
      end
      if (accept) begin
        base    <= pc_in;
        req_idx <= '0;
        rcv_idx <= '0;
      end
      if (complete) begin
        inst_valid_out <= 1'b1;
        inst_pc_out    <= base;
      end
      if (retire) begin
        inst_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_inst_fetch;
  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          pc_valid_in = 1'b0;
  logic          pc_ready_out;
  logic          mem_rd_en_out;
  logic [AW-1:0] mem_addr_out;
  logic          mem_grant_in = 1'b0;
  logic [7:0]    mem_din_in = 8'h00;
  logic          flush_in = 1'b0;
  logic [31:0]   inst_out;
  logic [AW-1:0] inst_pc_out;
  logic          inst_valid_out;
  logic          id_ready_in = 1'b0;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .pc_in(pc_in), .pc_valid_in(pc_valid_in), .pc_ready_out(pc_ready_out),
    .mem_rd_en_out(mem_rd_en_out), .mem_addr_out(mem_addr_out),
    .mem_grant_in(mem_grant_in), .mem_din_in(mem_din_in),
    .flush_in(flush_in), .inst_out(inst_out), .inst_pc_out(inst_pc_out),
    .inst_valid_out(inst_valid_out), .id_ready_in(id_ready_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] t;
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      default: begin
        t = a[7:0] * 8'd29;
        return t ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] p1, p2, p3;
    p1 = pc + 32'd1;
    p2 = pc + 32'd2;
    p3 = pc + 32'd3;
    return {mem_byte(p3), mem_byte(p2), mem_byte(p1), mem_byte(pc)};
  endfunction

  // One clock; acts as the memory, returning the granted byte in the following cycle, random data otherwise.
  task automatic step();
    logic        taken;
    logic [31:0] ta;
    @(negedge clk_in);
    taken = mem_rd_en_out & mem_grant_in;
    ta    = mem_addr_out;
    @(posedge clk_in);
    #1;
    mem_din_in = taken ? mem_byte(ta) : 8'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!inst_valid_out && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    #1 rst_in = 1'b0;
    #10;
    checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid_out); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst_out); end
    checks++; if (inst_pc_out !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc_out); end
    checks++; if (mem_rd_en_out !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", mem_rd_en_out); end
    checks++; if (mem_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr_out); end
    checks++; if (pc_ready_out !== 1'b1) begin errors++; $display("FAIL reset_pc_ready got %b exp 1", pc_ready_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_basic();
    pc_in = 32'h1000; pc_valid_in = 1'b1; mem_grant_in = 1'b1; id_ready_in = 1'b0;
    #1;
    checks++; if (pc_ready_out !== 1'b1) begin errors++; $display("FAIL basic_pc_ready got %b exp 1", pc_ready_out); end
    step();
    pc_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (mem_rd_en_out !== 1'b1) begin errors++; $display("FAIL basic_rd_en[%0d] got %b exp 1", k, mem_rd_en_out); end
      checks++; if (mem_addr_out !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL basic_addr[%0d] got %h exp %h", k, mem_addr_out, 32'h1000 + 32'(k)); end
      step();
    end
    checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", inst_valid_out); end
    step();
    checks++; if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid_at_5 got %b exp 1", inst_valid_out); end
    checks++; if (inst_out !== 32'h0010_0513) begin errors++; $display("FAIL basic_inst got %h exp 00100513", inst_out); end
    checks++; if (inst_pc_out !== 32'h1000) begin errors++; $display("FAIL basic_inst_pc got %h exp 00001000", inst_pc_out); end
    id_ready_in = 1'b1;
    step();
    id_ready_in = 1'b0;
    checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL basic_pop got %b exp 0", inst_valid_out); end
  endtask

  task automatic test_grant_stall();
    logic        gnt  [6];
    logic [31:0] addr [6];
    gnt  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    addr = '{32'h1000, 32'h1001, 32'h1002, 32'h1002, 32'h1002, 32'h1003};
    pc_in = 32'h1000; pc_valid_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_grant_in = gnt[k];
      #1;
      checks++; if (mem_addr_out !== addr[k] || mem_rd_en_out !== 1'b1) begin errors++; $display("FAIL stall_addr[%0d] got %h/%b exp %h/1", k, mem_addr_out, mem_rd_en_out, addr[k]); end
      step();
    end
    checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL stall_early_valid got %b exp 0", inst_valid_out); end
    step();
    checks++; if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid_at_7 got %b exp 1", inst_valid_out); end
    checks++; if (inst_out !== 32'h0010_0513) begin errors++; $display("FAIL stall_inst got %h exp 00100513", inst_out); end
  endtask

  task automatic test_hold();
    id_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h0010_0513 || inst_pc_out !== 32'h1000)
        begin errors++; $display("FAIL hold_stable[%0d] got %b/%h/%h exp 1/00100513/00001000", k, inst_valid_out, inst_out, inst_pc_out); end
      checks++; if (pc_ready_out !== 1'b0) begin errors++; $display("FAIL hold_pc_ready[%0d] got %b exp 0", k, pc_ready_out); end
    end
    id_ready_in = 1'b1;
    #1;
    checks++; if (pc_ready_out !== 1'b0) begin errors++; $display("FAIL hold_release_ready got %b exp 0", pc_ready_out); end
    step();
    id_ready_in = 1'b0;
    #1;
    checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL hold_drop got %b exp 0", inst_valid_out); end
    checks++; if (pc_ready_out !== 1'b1) begin errors++; $display("FAIL hold_ready_rise got %b exp 1", pc_ready_out); end
  endtask

  task automatic test_flush();
    int n;
    pc_in = 32'h1000; pc_valid_in = 1'b1; mem_grant_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    step();
    step();
    flush_in = 1'b1;
    #1;
    checks++; if (pc_ready_out !== 1'b0) begin errors++; $display("FAIL flush_gates_ready got %b exp 0", pc_ready_out); end
    step();
    flush_in = 1'b0;
    #1;
    checks++; if (pc_ready_out !== 1'b1 || mem_rd_en_out !== 1'b0) begin errors++; $display("FAIL flush_idle got ready %b rd %b exp 1 0", pc_ready_out, mem_rd_en_out); end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL flush_no_valid[%0d] got %b exp 0", k, inst_valid_out); end
    end
    pc_in = 32'h5000; pc_valid_in = 1'b1; flush_in = 1'b1;
    step();
    pc_valid_in = 1'b0; flush_in = 1'b0;
    #1;
    checks++; if (mem_rd_en_out !== 1'b0 || pc_ready_out !== 1'b1) begin errors++; $display("FAIL flush_pc_reject got rd %b ready %b exp 0 1", mem_rd_en_out, pc_ready_out); end
    pc_in = 32'h2000; pc_valid_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    wait_valid(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL flush_refetch_latency got %0d exp 5", n); end
    checks++; if (inst_out !== mem_word(32'h2000) || inst_pc_out !== 32'h2000) begin errors++; $display("FAIL flush_refetch got %h/%h exp %h/00002000", inst_out, inst_pc_out, mem_word(32'h2000)); end
    id_ready_in = 1'b1;
    step();
    id_ready_in = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a;
    pc_in = 32'hFFFF_FFFE; pc_valid_in = 1'b1; mem_grant_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    exp_a = 32'hFFFF_FFFE;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (mem_addr_out !== exp_a) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", k, mem_addr_out, exp_a); end
      exp_a = exp_a + 32'd1;
      step();
    end
    step();
    checks++; if (inst_valid_out !== 1'b1 || inst_pc_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_pc got %b/%h exp 1/fffffffe", inst_valid_out, inst_pc_out); end
    checks++; if (inst_out !== mem_word(32'hFFFF_FFFE)) begin errors++; $display("FAIL wrap_inst got %h exp %h", inst_out, mem_word(32'hFFFF_FFFE)); end
    id_ready_in = 1'b1;
    step();
    id_ready_in = 1'b0;
  endtask

  task automatic test_pause_reset();
    int n;
    pc_in = 32'h3000; pc_valid_in = 1'b1; mem_grant_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    step();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mem_rd_en_out !== 1'b0 || pc_ready_out !== 1'b0) begin errors++; $display("FAIL pause_quiet[%0d] got rd %b ready %b exp 0 0", k, mem_rd_en_out, pc_ready_out); end
      step();
    end
    rdy_in = 1'b1;
    #1;
    checks++; if (mem_rd_en_out !== 1'b1 || mem_addr_out !== 32'h3001) begin errors++; $display("FAIL pause_resume got %b/%h exp 1/00003001", mem_rd_en_out, mem_addr_out); end
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL pause_latency got %0d exp 4", n); end
    checks++; if (inst_out !== mem_word(32'h3000)) begin errors++; $display("FAIL pause_inst got %h exp %h", inst_out, mem_word(32'h3000)); end
    id_ready_in = 1'b1;
    step();
    id_ready_in = 1'b0;

    pc_in = 32'h4000; pc_valid_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    step();
    rst_in = 1'b0;
    #1;
    checks++; if (inst_valid_out !== 1'b0 || inst_out !== 32'h0 || inst_pc_out !== 32'h0) begin errors++; $display("FAIL rst_mid_outs got %b/%h/%h exp 0/0/0", inst_valid_out, inst_out, inst_pc_out); end
    checks++; if (mem_rd_en_out !== 1'b0 || mem_addr_out !== 32'h0) begin errors++; $display("FAIL rst_mid_mem got %b/%h exp 0/0", mem_rd_en_out, mem_addr_out); end
    #1 rst_in = 1'b1;
    step();
    checks++; if (inst_out !== 32'h0 || mem_rd_en_out !== 1'b0 || pc_ready_out !== 1'b1) begin errors++; $display("FAIL rst_stale_byte got %h/%b/%b exp 0/0/1", inst_out, mem_rd_en_out, pc_ready_out); end
    pc_in = 32'h4000; pc_valid_in = 1'b1;
    step();
    pc_valid_in = 1'b0;
    wait_valid(n);
    checks++; if (n !== 5 || inst_out !== mem_word(32'h4000)) begin errors++; $display("FAIL rst_recover got %0d/%h exp 5/%h", n, inst_out, mem_word(32'h4000)); end
    id_ready_in = 1'b1;
    step();
    id_ready_in = 1'b0;
  endtask

  // Model: an accepted PC needs four granted reads in order; the word appears the edge after the
  // fourth grant and stays until decode takes it; a flush abandons everything.
  task automatic test_random();
    int          mode;   // 0 waiting for PC, 1 fetching, 2 holding word
    int          grants;
    bit          last_due;
    logic [31:0] cur;
    bit          pv, gr, fl, idr, exp_rd;
    logic [31:0] pcv;
    mode = 0; grants = 0; last_due = 1'b0; cur = '0;
    rdy_in = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      pv  = ($urandom_range(0, 1) == 1);
      pcv = $urandom;
      gr  = ($urandom_range(0, 3) != 0);
      idr = ($urandom_range(0, 4) < 2);
      fl  = ($urandom_range(0, 24) == 0);
      pc_valid_in = pv; pc_in = pcv; mem_grant_in = gr; id_ready_in = idr; flush_in = fl;
      #1;
      exp_rd = (mode == 1) && (grants < 4);
      checks++; if (mem_rd_en_out !== exp_rd) begin errors++; $display("FAIL rnd_rd_en c%0d got %b exp %b", c, mem_rd_en_out, exp_rd); end
      checks++; if (pc_ready_out !== ((mode == 0) && !fl)) begin errors++; $display("FAIL rnd_pc_ready c%0d got %b exp %b", c, pc_ready_out, (mode == 0) && !fl); end
      if (exp_rd) begin
        checks++; if (mem_addr_out !== cur + 32'(grants)) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, mem_addr_out, cur + 32'(grants)); end
      end
      step();
      if (fl) begin
        mode = 0; last_due = 1'b0;
      end else if (mode == 0) begin
        if (pv) begin mode = 1; cur = pcv; grants = 0; last_due = 1'b0; end
      end else if (mode == 1) begin
        if (last_due) begin
          mode = 2; last_due = 1'b0;
        end else if (exp_rd && gr) begin
          grants++;
          if (grants == 4) last_due = 1'b1;
        end
      end else if (idr) begin
        mode = 0;
      end
      checks++; if (inst_valid_out !== (mode == 2)) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, inst_valid_out, mode == 2); end
      if (mode == 2) begin
        checks++; if (inst_out !== mem_word(cur) || inst_pc_out !== cur) begin errors++; $display("FAIL rnd_word c%0d got %h/%h exp %h/%h", c, inst_out, inst_pc_out, mem_word(cur), cur); end
      end
    end
    pc_valid_in = 1'b0; flush_in = 1'b0; id_ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_stall();
    test_hold();
    test_flush();
    test_wrap();
    test_pause_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
